// File: rtl/i2s_pkg.sv
// Shared size codes, state encoding and size-to-width helpers for the
// I2S sample scheduler.
package i2s_pkg;

  typedef logic [3:0] size_t;

  localparam size_t SZ_8  = 4'd0;
  localparam size_t SZ_12 = 4'd1;
  localparam size_t SZ_16 = 4'd3;
  localparam size_t SZ_32 = 4'd5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_MUTE  = 3'd4;

  function automatic size_t size_norm(input size_t c);
    case (c)
      SZ_8, SZ_12, SZ_16, SZ_32: return c;
      default: return SZ_16;
    endcase
  endfunction

  function automatic logic [5:0] size_width(input size_t c);
    case (size_norm(c))
      SZ_8:    return 6'd8;
      SZ_12:   return 6'd12;
      SZ_32:   return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input size_t c);
    logic [5:0] w;
    w = size_width(c);
    if (w == 6'd32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/i2s_sample_scheduler_if.sv
// Config, FIFO and serializer signals of the I2S sample scheduler.
// master = scheduler side, slave = environment side.
interface i2s_sample_scheduler_if;
  import i2s_pkg::*;

  logic        cfg_enable;
  size_t       cfg_size;
  logic        fifo_empty;
  logic [63:0] fifo_data;
  logic        fifo_rd_en;
  logic        ser_ws;
  logic        ser_start;
  logic [31:0] ser_left;
  logic [31:0] ser_right;
  size_t       ser_size;
  logic        running;
  logic [15:0] underrun_cnt;

  modport master (
    input  cfg_enable, cfg_size, fifo_empty, fifo_data, ser_ws,
    output fifo_rd_en, ser_start, ser_left, ser_right,
    output ser_size, running, underrun_cnt
  );

  modport slave (
    output cfg_enable, cfg_size, fifo_empty, fifo_data, ser_ws,
    input  fifo_rd_en, ser_start, ser_left, ser_right,
    input  ser_size, running, underrun_cnt
  );

endinterface

// File: rtl/i2s_sample_mask.sv
// Clears sample bits at and above the width selected by a size code.
module i2s_sample_mask
  import i2s_pkg::*;
(
  input  size_t       size_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  assign data_o = data_i & size_mask(size_i);

endmodule

// File: rtl/i2s_sample_scheduler.sv
// I2S sample scheduler: pops stereo pairs at each ws rising edge.
// I2S_UNDERRUN_REPEAT_EN: underrun repeats last pair instead of zeros.
module i2s_sample_scheduler
  import i2s_pkg::*;
(
  input logic clk,
  input logic rst,
  i2s_sample_scheduler_if.master bus
);

`ifdef I2S_UNDERRUN_REPEAT_EN
  localparam bit FILL_ZERO = 1'b0;
`else
  localparam bit FILL_ZERO = 1'b1;
`endif

  logic [2:0]  state_q, state_d;
  logic        ws_q;
  logic        ld_q, ld_d;
  logic        zr_q, zr_d;
  logic        start_q;
  size_t       size_q;
  logic [31:0] left_q, right_q;
  logic [31:0] left_m, right_m;
  logic [15:0] urun_q;
  logic        fetch_pt;
  logic        urun;

  assign fetch_pt = bus.ser_ws & ~ws_q;

  always_comb begin
    state_d = state_q;
    ld_d    = 1'b0;
    zr_d    = 1'b0;
    urun    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_enable && !bus.fifo_empty)
          state_d = S_FETCH;
      end
      S_FETCH: begin
        ld_d    = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_RUN;
      S_RUN, S_MUTE: begin
        if (fetch_pt) begin
          if (!bus.cfg_enable) begin
            zr_d    = 1'b1;
            state_d = S_MUTE;
          end else begin
            state_d = S_RUN;
            if (!bus.fifo_empty) begin
              ld_d = 1'b1;
            end else begin
              urun = 1'b1;
              zr_d = FILL_ZERO;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  i2s_sample_mask u_mask_l (
    .size_i (size_q),
    .data_i (bus.fifo_data[63:32]),
    .data_o (left_m)
  );

  i2s_sample_mask u_mask_r (
    .size_i (size_q),
    .data_i (bus.fifo_data[31:0]),
    .data_o (right_m)
  );

  // FIFO data is valid the cycle after the pop, so the capture
  // (or zero fill) is applied one cycle after the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ws_q    <= 1'b1;
      ld_q    <= 1'b0;
      zr_q    <= 1'b0;
      start_q <= 1'b0;
      size_q  <= SZ_16;
      left_q  <= '0;
      right_q <= '0;
      urun_q  <= '0;
    end else begin
      state_q <= state_d;
      ws_q    <= bus.ser_ws;
      ld_q    <= ld_d;
      zr_q    <= zr_d;
      start_q <= (state_q == S_LOAD);
      if (state_q == S_IDLE)
        size_q <= size_norm(bus.cfg_size);
      if (ld_q) begin
        left_q  <= left_m;
        right_q <= right_m;
      end else if (zr_q) begin
        left_q  <= '0;
        right_q <= '0;
      end
      if (urun && urun_q != 16'hFFFF)
        urun_q <= urun_q + 16'd1;
    end
  end

  assign bus.fifo_rd_en   = ld_d;
  assign bus.ser_start    = start_q;
  assign bus.ser_left     = left_q;
  assign bus.ser_right    = right_q;
  assign bus.ser_size     = size_q;
  assign bus.running      = (state_q == S_RUN);
  assign bus.underrun_cnt = urun_q;

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Directed bench for i2s_sample_scheduler with a FIFO model and a
// scoreboard of expected sample pairs.
module tb_i2s_sample_scheduler;

  logic clk = 1'b0;
  logic rst;

  i2s_sample_scheduler_if bus ();

  i2s_sample_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] fifo_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int start_cnt = 0;
  int due = 0;
  int tbits = 16;

  function automatic int bits_of(input logic [3:0] c);
    case (c)
      4'd0:    return 8;
      4'd1:    return 12;
      4'd5:    return 32;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] mdl(input logic [63:0] p);
    logic [31:0] m;
    case (tbits)
      8:       m = 32'h0000_00FF;
      12:      m = 32'h0000_0FFF;
      16:      m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return {p[63:32] & m, p[31:0] & m};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic rd;
    #1;
    rd = bus.fifo_rd_en;
    if (rd) begin
      rd_cnt++;
      if (fifo_q.size() > 0) begin
        last_exp = mdl(fifo_q[0]);
        exp_q.push_back(last_exp);
        due = 2;
      end
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    if (bus.ser_start) start_cnt++;
    if (due > 0) begin
      due--;
      if (due == 0)
        chk("pair", {bus.ser_left, bus.ser_right}, exp_q.pop_front());
    end
  endtask

  task automatic push(input logic [63:0] p);
    fifo_q.push_back(p);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic frame();
    bus.ser_ws = 1'b0;
    repeat (4) cyc();
    bus.ser_ws = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    due = 0;
    exp_q.delete();
    fifo_q.delete();
    bus.fifo_empty = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    rd_cnt = 0;
    start_cnt = 0;
  endtask

  logic [3:0] codes[3] = '{4'd1, 4'd0, 4'd5};

  initial begin
    rst = 1'b1;
    bus.cfg_enable = 1'b0;
    bus.cfg_size = 4'd3;
    bus.ser_ws = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data = '0;
    last_exp = '0;
    @(negedge clk);
    do_reset();

    chk("rst_pair", {bus.ser_left, bus.ser_right}, 64'd0);
    chk("rst_size", 64'(bus.ser_size), 64'd3);
    chk("rst_flags", 64'({bus.running, bus.fifo_rd_en, bus.ser_start}), 64'd0);
    chk("rst_urun", 64'(bus.underrun_cnt), 64'd0);

    // first pair after enable
    tbits = 16;
    push(64'h12345678_9ABCDEF0);
    bus.cfg_enable = 1'b1;
    repeat (3) cyc();
    chk("load_pair", {bus.ser_left, bus.ser_right}, 64'h00005678_0000DEF0);
    chk("load_start", 64'(bus.ser_start), 64'd1);
    cyc();
    chk("load_rd_cnt", 64'(rd_cnt), 64'd1);
    chk("load_start_cnt", 64'(start_cnt), 64'd1);
    chk("load_running", 64'(bus.running), 64'd1);

    // steady stream of four pairs
    rd_cnt = 0;
    push(64'hA1B2C3D4_E5F60718);
    push(64'h0F0F0F0F_F0F0F0F0);
    push(64'hFFFFFFFF_00000001);
    push(64'h13572468_8642ACE0);
    repeat (4) frame();
    chk("stream_rd_cnt", 64'(rd_cnt), 64'd4);
    chk("stream_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("stream_hold", {bus.ser_left, bus.ser_right}, 64'h00002468_0000ACE0);
    chk("stream_start_cnt", 64'(start_cnt), 64'd1);

    // three underruns
    rd_cnt = 0;
    repeat (3) frame();
    chk("urun_cnt", 64'(bus.underrun_cnt), 64'd3);
    chk("urun_rd_cnt", 64'(rd_cnt), 64'd0);
`ifdef I2S_UNDERRUN_REPEAT_EN
    chk("urun_fill", {bus.ser_left, bus.ser_right}, last_exp);
`else
    chk("urun_fill", {bus.ser_left, bus.ser_right}, 64'd0);
`endif

    // resume, mute, unmute; size change in RUN must not take effect
    bus.cfg_size = 4'd0;
    push(64'h11112222_33334444);
    push(64'h55556666_77778888);
    rd_cnt = 0;
    frame();
    chk("resume_rd_cnt", 64'(rd_cnt), 64'd1);
    chk("run_size_frozen", 64'(bus.ser_size), 64'd3);
    bus.cfg_enable = 1'b0;
    rd_cnt = 0;
    repeat (2) frame();
    chk("mute_pair", {bus.ser_left, bus.ser_right}, 64'd0);
    chk("mute_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("mute_state", 64'(dut.state_q), 64'd4);
    chk("mute_running", 64'(bus.running), 64'd0);
    chk("mute_urun", 64'(bus.underrun_cnt), 64'd3);
    bus.cfg_enable = 1'b1;
    frame();
    chk("unmute_rd_cnt", 64'(rd_cnt), 64'd1);
    chk("unmute_pair", {bus.ser_left, bus.ser_right}, 64'h00006666_00008888);
    chk("unmute_running", 64'(bus.running), 64'd1);

    // masking at each other width
    foreach (codes[i]) begin
      bus.cfg_enable = 1'b0;
      bus.cfg_size = codes[i];
      tbits = bits_of(codes[i]);
      do_reset();
      push(64'hDEADBEEF_CAFEF00D);
      bus.cfg_enable = 1'b1;
      repeat (5) cyc();
      chk("size_code", 64'(bus.ser_size), 64'(codes[i]));
      chk("size_start_cnt", 64'(start_cnt), 64'd1);
    end
    chk("size32_pair", {bus.ser_left, bus.ser_right}, 64'hDEADBEEF_CAFEF00D);

    // invalid size code, then reset while in LOAD
    bus.cfg_enable = 1'b0;
    bus.cfg_size = 4'd6;
    tbits = 16;
    do_reset();
    cyc();
    chk("size_invalid", 64'(bus.ser_size), 64'd3);
    push(64'h01234567_89ABCDEF);
    bus.cfg_enable = 1'b1;
    repeat (2) cyc();
    chk("pre_rst_state", 64'(dut.state_q), 64'd2);
    rst = 1'b1;
    due = 0;
    exp_q.delete();
    start_cnt = 0;
    cyc();
    chk("load_rst_pair", {bus.ser_left, bus.ser_right}, 64'd0);
    chk("load_rst_flags",
        64'({bus.running, bus.fifo_rd_en, bus.ser_start}), 64'd0);
    chk("load_rst_size", 64'(bus.ser_size), 64'd3);
    chk("load_rst_urun", 64'(bus.underrun_cnt), 64'd0);
    rst = 1'b0;
    bus.cfg_enable = 1'b0;
    repeat (3) cyc();
    chk("load_rst_no_start", 64'(start_cnt), 64'd0);
    chk("load_rst_no_capture", {bus.ser_left, bus.ser_right}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
